// File: rtl/pll_lock_seq_if.sv
// Status/control bundle between the PLL lock sequencer and its surroundings.
// The master side drives lock and restart; the slave (sequencer) drives status.
interface pll_lock_seq_if;
    logic       pll_lock;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       locked;
    logic       fault;
    logic [7:0] relock_cnt;
    logic [2:0] state;

    modport master (
        output pll_lock,
        output restart,
        input  pll_rst,
        input  sys_rst_n,
        input  locked,
        input  fault,
        input  relock_cnt,
        input  state
    );

    modport slave (
        input  pll_lock,
        input  restart,
        output pll_rst,
        output sys_rst_n,
        output locked,
        output fault,
        output relock_cnt,
        output state
    );
endinterface

// File: rtl/pll_lock_seq.sv
// Reset/lock sequencer for the GTP_PLL_E1: pulses the PLL reset, qualifies LOCK,
// releases the system reset after a stable lock window, re-locks on loss, faults on retries.
module pll_lock_seq #(
    parameter int unsigned RST_CYCLES    = 50,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned LOSS_FILTER   = 4,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pll_lock_seq_if.slave  bus
);

    localparam int unsigned RETRY_W = (MAX_RETRY   < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned LOSS_W  = (LOSS_FILTER < 2) ? 1 : $clog2(LOSS_FILTER + 1);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);
    localparam logic [LOSS_W-1:0]  LOSS_LAST   = LOSS_W'(LOSS_FILTER - 1);

    typedef enum logic [2:0] {
        S_RESET_HOLD = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABLE     = 3'd2,
        S_RUN        = 3'd3,
        S_FAULT      = 3'd4
    } state_e;

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   timer_q,   timer_d;
    logic [RETRY_W-1:0] retry_q,   retry_d;
    logic [RETRY_W-1:0] retry_inc;
    logic [LOSS_W-1:0]  loss_q,    loss_d;
    logic [7:0]         relock_q,  relock_d;
    logic               lk_meta_q, lk_s_q;
    logic               pll_rst_q, sys_rst_n_q, locked_q, fault_q;

    // Two-flop synchroniser for the asynchronous PLL LOCK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta_q <= 1'b0;
            lk_s_q    <= 1'b0;
        end else begin
            lk_meta_q <= bus.pll_lock;
            lk_s_q    <= lk_meta_q;
        end
    end

    assign retry_inc = retry_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        loss_d   = '0;
        relock_d = relock_q;

        if (bus.restart) begin
            state_d = S_RESET_HOLD;
            retry_d = '0;
        end else begin
            case (state_q)
                S_RESET_HOLD: begin
                    if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lk_s_q) begin
                        state_d = S_STABLE;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_MAX) ? S_FAULT : S_RESET_HOLD;
                    end
                end
                S_STABLE: begin
                    if (!lk_s_q) begin
                        state_d = S_WAIT_LOCK;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        retry_d = '0;
                    end
                end
                S_RUN: begin
                    // Loss counter only survives consecutive low samples; any high sample clears it.
                    if (!lk_s_q) begin
                        if (loss_q == LOSS_LAST) begin
                            state_d = S_RESET_HOLD;
                            if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                        end else begin
                            loss_d = loss_q + 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_RESET_HOLD;
                end
            endcase
        end

        // A restart begins a fresh sequence even when already in RESET_HOLD.
        if (bus.restart || (state_d != state_q)) timer_d = '0;
        else                                     timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RESET_HOLD;
            timer_q  <= '0;
            retry_q  <= '0;
            loss_q   <= '0;
            relock_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            loss_q   <= loss_d;
            relock_q <= relock_d;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            pll_rst_q   <= (state_d == S_RESET_HOLD) || (state_d == S_FAULT);
            sys_rst_n_q <= (state_d == S_RUN);
            locked_q    <= (state_d == S_RUN);
            fault_q     <= (state_d == S_FAULT);
        end
    end

    assign bus.pll_rst    = pll_rst_q;
    assign bus.sys_rst_n  = sys_rst_n_q;
    assign bus.locked     = locked_q;
    assign bus.fault      = fault_q;
    assign bus.relock_cnt = relock_q;
    assign bus.state      = state_q;

endmodule
